// File: rtl/gray_pkg.sv
// Shared Gray-code helpers used by the counter, the downstream converter and the bench.
// Functions work on a 16-bit container; narrower codes are passed zero-extended.
package gray_pkg;

   localparam int GRAY_W_DEFAULT = 4;
   localparam int GRAY_W_MAX     = 16;

   function automatic logic [GRAY_W_MAX-1:0] bin2gray(input logic [GRAY_W_MAX-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits leave the lower prefix-XOR unchanged, so any W <= 16 works.
   function automatic logic [GRAY_W_MAX-1:0] gray2bin(input logic [GRAY_W_MAX-1:0] g);
      logic [GRAY_W_MAX-1:0] b;
      b[GRAY_W_MAX-1] = g[GRAY_W_MAX-1];
      for (int i = GRAY_W_MAX-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/gray_counter.sv
// W-bit Gray-code counter with clear, binary load, up/down stepping and wrap/saturate ends.
// g and changed are registered; tc is combinational from the current count and up.
module gray_counter
   import gray_pkg::*;
#(
   parameter int W    = GRAY_W_DEFAULT,
   parameter bit WRAP = 1'b1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         up,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] load_bin,
   output logic [W-1:0] g,
   output logic         changed,
   output logic         tc
);

   localparam logic [W-1:0] ONE  = W'(1);
   localparam logic [W-1:0] ONES = {W{1'b1}};

   logic [W-1:0] bin_q, bin_d;
   logic [W-1:0] g_q, g_d;
   logic         changed_q, changed_d;
   logic         at_term;

   function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
      return W'(bin2gray(GRAY_W_MAX'(b)));
   endfunction

   assign at_term = up ? (bin_q == ONES) : (bin_q == '0);

   always_comb begin
      bin_d     = bin_q;
      g_d       = g_q;
      changed_d = 1'b0;
      if (clr) begin
         bin_d     = '0;
         g_d       = '0;
         changed_d = (g_q != '0);
      end else if (load) begin
         bin_d     = load_bin;
         g_d       = to_gray(load_bin);
         changed_d = (g_d != g_q);
      end else if (en) begin
         // Saturating variant simply ignores an en step at the terminal value.
         if (!at_term || WRAP) begin
            bin_d     = up ? (bin_q + ONE) : (bin_q - ONE);
            g_d       = to_gray(bin_d);
            changed_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q     <= '0;
         g_q       <= '0;
         changed_q <= 1'b0;
      end else begin
         bin_q     <= bin_d;
         g_q       <= g_d;
         changed_q <= changed_d;
      end
   end

   assign g       = g_q;
   assign changed = changed_q;
   assign tc      = at_term;

endmodule

// File: tb/tb_gray_counter.sv
// Bench for gray_counter: a wrapping and a saturating instance share stimulus and are
// checked against an integer model, plus fixed vector tables and corner sequences.
module tb_gray_counter;
   import gray_pkg::*;

   localparam int W    = 4;
   localparam int MAXV = (1 << W) - 1;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         en = 1'b0, up = 1'b1, clr = 1'b0, load = 1'b0;
   logic [W-1:0] load_bin = '0;

   logic [W-1:0] g_w, g_s, conv_w, conv_s;
   logic         changed_w, changed_s, tc_w, tc_s;

   int n_checks = 0;
   int n_fail   = 0;
   int mb_w = 0;
   int mb_s = 0;

   always #5 clk = ~clk;

   gray_counter #(.W(W), .WRAP(1'b1)) dut_w (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_bin(load_bin), .g(g_w), .changed(changed_w), .tc(tc_w)
   );

   gray_counter #(.W(W), .WRAP(1'b0)) dut_s (
      .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
      .load_bin(load_bin), .g(g_s), .changed(changed_s), .tc(tc_s)
   );

   // Downstream converter stage fed by each counter.
   assign conv_w = W'(gray2bin(GRAY_W_MAX'(g_w)));
   assign conv_s = W'(gray2bin(GRAY_W_MAX'(g_s)));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int gray_of(input int b);
      return b ^ (b >> 1);
   endfunction

   function automatic int model_next(input int b, input bit wrap, input bit e, input bit u,
                                     input bit c, input bit l, input int lb);
      if (c) return 0;
      if (l) return lb;
      if (!e) return b;
      if (wrap) return u ? (b + 1) % (MAXV + 1) : (b + MAXV) % (MAXV + 1);
      if (u) return (b < MAXV) ? b + 1 : MAXV;
      return (b > 0) ? b - 1 : 0;
   endfunction

   function automatic bit model_tc(input int b, input bit u);
      return u ? (b == MAXV) : (b == 0);
   endfunction

   // One clock: drive at negedge, sample tc before the edge, check registered outputs after.
   task automatic step(input bit e, input bit u, input bit c, input bit l,
                       input logic [W-1:0] lb, output logic tc_pre);
      int nb_w, nb_s;
      logic [W-1:0] old_w, old_s;
      @(negedge clk);
      en = e; up = u; clr = c; load = l; load_bin = lb;
      #1;
      tc_pre = tc_w;
      check("tc_wrap", 32'(tc_w), 32'(model_tc(mb_w, u)));
      check("tc_sat",  32'(tc_s), 32'(model_tc(mb_s, u)));
      old_w = g_w;
      old_s = g_s;
      nb_w = model_next(mb_w, 1'b1, e, u, c, l, int'(lb));
      nb_s = model_next(mb_s, 1'b0, e, u, c, l, int'(lb));
      @(posedge clk);
      #1;
      check("g_wrap",       32'(g_w),       32'(gray_of(nb_w)));
      check("changed_wrap", 32'(changed_w), 32'(gray_of(nb_w) != gray_of(mb_w)));
      check("roundtrip_wrap", 32'(conv_w),  32'(nb_w));
      check("g_sat",        32'(g_s),       32'(gray_of(nb_s)));
      check("changed_sat",  32'(changed_s), 32'(gray_of(nb_s) != gray_of(mb_s)));
      check("roundtrip_sat", 32'(conv_s),   32'(nb_s));
      if (e && !c && !l) begin
         check("onebit_wrap", 32'($countones(g_w ^ old_w)), 32'd1);
         check("onebit_sat",  32'($countones(g_s ^ old_s)), (nb_s != mb_s) ? 32'd1 : 32'd0);
      end
      mb_w = nb_w;
      mb_s = nb_s;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
      #2;
      rst = 1'b0;
      mb_w = 0;
      mb_s = 0;
   endtask

   typedef struct {
      bit           en, up, clr, load;
      logic [W-1:0] lb;
      logic [W-1:0] exp_g;
      bit           exp_chg;
      bit           exp_tc;
   } vec_t;

   vec_t vecs[$];
   logic tcp;

   initial begin
      // Vectors for the wrapping instance, starting from reset (bin 0).
      vecs.push_back('{1, 1, 0, 0, 4'h0, 4'b0001, 1, 0});
      vecs.push_back('{1, 1, 0, 0, 4'h0, 4'b0011, 1, 0});
      vecs.push_back('{0, 1, 0, 1, 4'hD, 4'b1011, 1, 0});
      vecs.push_back('{1, 1, 0, 0, 4'h0, 4'b1001, 1, 0});
      vecs.push_back('{1, 1, 0, 0, 4'h0, 4'b1000, 1, 0});
      vecs.push_back('{1, 1, 0, 0, 4'h0, 4'b0000, 1, 1});
      vecs.push_back('{0, 0, 0, 0, 4'h0, 4'b0000, 0, 1});
      vecs.push_back('{1, 0, 0, 0, 4'h0, 4'b1000, 1, 1});
      vecs.push_back('{1, 0, 0, 0, 4'h0, 4'b1001, 1, 0});
      vecs.push_back('{1, 0, 1, 1, 4'h5, 4'b0000, 1, 0});
      vecs.push_back('{0, 0, 1, 0, 4'h0, 4'b0000, 0, 1});
      vecs.push_back('{0, 1, 0, 1, 4'h0, 4'b0000, 0, 0});
      vecs.push_back('{0, 1, 0, 1, 4'h5, 4'b0111, 1, 0});

      // Reset state, tc follows !up.
      repeat (2) @(posedge clk);
      #1;
      check("reset_g",       32'(g_w),       32'd0);
      check("reset_changed", 32'(changed_w), 32'd0);
      check("reset_g_sat",   32'(g_s),       32'd0);
      up = 1'b0; #1;
      check("reset_tc_down", 32'(tc_w), 32'd1);
      up = 1'b1; #1;
      check("reset_tc_up",   32'(tc_w), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].up, vecs[i].clr, vecs[i].load, vecs[i].lb, tcp);
         check($sformatf("vec%0d_tc", i),  32'(tcp),       32'(vecs[i].exp_tc));
         check($sformatf("vec%0d_g", i),   32'(g_w),       32'(vecs[i].exp_g));
         check($sformatf("vec%0d_chg", i), 32'(changed_w), 32'(vecs[i].exp_chg));
      end

      // Full up count with wrap after reset: 16 steps return to zero.
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1, 1, 0, 0, 4'h0, tcp);
         check("upcount_chg", 32'(changed_w), 32'd1);
      end
      check("upcount_end", 32'(g_w), 32'(gray_of(1)));

      // Down from reset: first step wraps to bin 15.
      do_reset();
      step(1, 0, 0, 0, 4'h0, tcp);
      check("down_tc_pre", 32'(tcp), 32'd1);
      check("down_first",  32'(g_w), 32'b1000);
      step(1, 0, 0, 0, 4'h0, tcp);
      check("down_second", 32'(g_w), 32'b1001);

      // Saturating instance holds at the top.
      do_reset();
      step(0, 1, 0, 1, 4'hE, tcp);
      check("sat_load", 32'(g_s), 32'b1001);
      step(1, 1, 0, 0, 4'h0, tcp);
      check("sat_step", 32'(g_s), 32'b1000);
      check("sat_step_chg", 32'(changed_s), 32'd1);
      step(1, 1, 0, 0, 4'h0, tcp);
      check("sat_hold", 32'(g_s), 32'b1000);
      check("sat_hold_chg", 32'(changed_s), 32'd0);

      // Priority: clr beats load and en, then load alone.
      step(0, 1, 0, 1, 4'h4, tcp);
      check("prio_pre", 32'(g_w), 32'b0110);
      step(1, 1, 1, 1, 4'h5, tcp);
      check("prio_clr", 32'(g_w), 32'b0000);
      check("prio_clr_chg", 32'(changed_w), 32'd1);
      step(0, 1, 0, 1, 4'h5, tcp);
      check("prio_load", 32'(g_w), 32'b0111);

      // Asynchronous reset between edges.
      step(0, 1, 0, 1, 4'hC, tcp);
      check("async_pre", 32'(g_w), 32'b1010);
      #2;
      rst = 1'b1; en = 1'b0; clr = 1'b0; load = 1'b0;
      #1;
      check("async_g",   32'(g_w),       32'd0);
      check("async_chg", 32'(changed_w), 32'd0);
      #1;
      rst = 1'b0;
      mb_w = 0;
      mb_s = 0;
      step(1, 1, 0, 0, 4'h0, tcp);
      check("async_resume", 32'(g_w), 32'b0001);

      // Random stimulus against the model.
      for (int i = 0; i < 1000; i++) begin
         step(($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
              ($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
              W'($urandom_range(0, MAXV)), tcp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      n_fail++;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/gray_counter.md
Name: gray_counter

Overview:
- Synchronous W-bit Gray-code counter.
- Sits directly upstream of the Gray-to-binary converter and drives its g input.
- Supports up/down counting, synchronous clear, binary load, and wrap or saturate at the ends of the range.
- Emits a one-cycle strobe on every code change so the downstream stage knows when a new code is present.

Parameters:
- W, 4, counter width in bits (range 2..16).
- WRAP, 1, 1 = wrap at the ends of the range; 0 = saturate (hold at end).

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- up  input  1  direction: 1 = increment, 0 = decrement.
- clr  input  1  synchronous clear to zero.
- load  input  1  synchronous load from load_bin.
- load_bin  input  W  binary value to load; converted to Gray internally.
- g  output  W  registered Gray-code count; feeds the converter.
- changed  output  1  registered; high for exactly one cycle after g takes a new value.
- tc  output  1  combinational terminal count: (up && bin==2^W-1) || (!up && bin==0).

Behaviour:
- State:
  - Internal binary register bin[W-1:0].
  - Output register g, always equal to bin ^ (bin>>1) from the cycle after any update.
- Reset (async, rst=1):
  - bin=0, g=0, changed=0 immediately, independent of clk.
  - tc then equals !up.
- Priority per rising edge: clr > load > en. Exactly one action per cycle.
  - clr=1: bin<=0, g<=0. changed<=1 iff g was nonzero, else 0.
  - load=1 (clr=0): bin<=load_bin, g<=gray(load_bin). changed<=1 iff gray(load_bin)!=g.
  - en=1 (clr=0, load=0):
    - Not at terminal: bin<=bin±1, g updated, changed<=1.
    - At terminal, WRAP=1: bin wraps (2^W-1 -> 0 counting up; 0 -> 2^W-1 counting down), changed<=1.
    - At terminal, WRAP=0: bin holds, g holds, changed<=0.
  - No action: everything holds, changed<=0.
- Latency: one cycle from control input to new g.
- Gray property: any en-step (including wrap) changes exactly one bit of g. clr and load may change several bits.
- Direction:
  - up is sampled on the same edge as en.
  - Changing up between cycles is legal and takes effect immediately.
- No handshake back-pressure: the downstream converter is combinational and always ready.
- Reset mid-count overrides everything asynchronously. On rst deassertion the first edge with en=1 yields g=gray(1) for up, or gray(2^W-1) for down with WRAP=1.
- Arithmetic is modulo 2^W; no width extension. load_bin is used as-is.

Decomposition:
- Shared package gray_pkg holds:
  - function bin2gray(W-bit): b ^ (b>>1)
  - function gray2bin, for bench checking and for reuse by the converter
  - constant GRAY_W_DEFAULT = 4
- No sub-module; the counter is a single flat module using the package functions.
- The bench instantiates gray_counter feeding the existing converter and checks the round-trip: converter output == internal bin.

Test Plan:
- Reset then up count (W=4, WRAP=1): rst pulse, en=1, up=1 for 17 cycles -> g = 0000,0001,0011,0010,0110,…,1000,0000. changed=1 each cycle. Exactly one bit differs per step. tc=1 when g=1000.
- Down wrap: after reset, en=1, up=0 -> first g=1000 (bin 15), then 1001 (bin 14). tc=1 in the cycle before the first step.
- Saturate (WRAP=0): load_bin=4'b1110, then en=1, up=1 for 3 cycles -> g=1001, then 1000, then 1000 held. changed=1,1,0.
- Priority: clr=1, load=1, load_bin=0101, en=1 in the same cycle with g=0110 -> g=0000, changed=1. Next cycle load=1 alone -> g=0111.
- Async reset mid-count: rst asserted between edges while g=1010 -> g=0000 and changed=0 before the next edge. Counting resumes from 0 after release.
- Round-trip: random en/up/load for 1000 cycles into the downstream converter -> converter b == model binary count every cycle. The one-bit-change check holds on every en step.
